// File: rtl/eth_pkt_gen.sv
// eth_pkt_gen: Ethernet test-traffic generator for the ICMP/UDP TX engines.
// Emits campaigns of packets with stepped payload lengths and a selectable
// payload pattern, separated by a fixed idle gap. A watchdog aborts a packet
// whose tx_done never arrives; the same length is then retried.
//
// Ports:
//   gmii_tx_clk  - clock, rising edge
//   rst_n        - async active-low reset
//   gen_en       - campaign enable (level)
//   pattern_mode - payload pattern, latched when a campaign starts
//   tx_start_en  - one-cycle start pulse to the TX engine
//   tx_byte_num  - payload length, held from start pulse to tx_done
//   tx_data      - payload word
//   tx_req       - engine requests next word
//   tx_done      - engine finished the packet (pulse)
//   busy         - high outside IDLE
//   pkt_cnt      - packets completed in current campaign
//   gen_done     - pulse when PKT_NUM packets have completed
//   timeout_err  - sticky watchdog abort flag
module eth_pkt_gen #(
  parameter int          DATA_W     = 32,
  parameter logic [15:0] LEN_MIN    = 16'd20,
  parameter logic [15:0] LEN_MAX    = 16'd28,
  parameter logic [15:0] LEN_STEP   = 16'd8,
  parameter int          GAP_CYCLES = 100,
  parameter logic [15:0] PKT_NUM    = 16'd0,
  parameter int          TIMEOUT    = 4096
) (
  input  logic              gmii_tx_clk,
  input  logic              rst_n,
  input  logic              gen_en,
  input  logic [1:0]        pattern_mode,
  output logic              tx_start_en,
  output logic [15:0]       tx_byte_num,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_req,
  input  logic              tx_done,
  output logic              busy,
  output logic [15:0]       pkt_cnt,
  output logic              gen_done,
  output logic              timeout_err
);

  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        mode;
  logic [15:0]       cur_len;
  logic [WD_W-1:0]   wdog;
  logic [GAP_W-1:0]  gap_cnt;
  logic              armed;
  logic              go, pkt_ok, abort, camp_done;
  logic [16:0]       len_sum;

  function automatic logic [DATA_W-1:0] seed_of(input logic [1:0] m);
    case (m)
      2'd1:    return {(DATA_W/8){8'hA5}};
      2'd2:    return DATA_W'(1);
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] next_of(input logic [1:0] m,
                                                input logic [DATA_W-1:0] d);
    case (m)
      2'd0:    return d + DATA_W'(1);
      2'd1:    return d;
      2'd2:    return {d[DATA_W-2:0], d[DATA_W-1]};
      default: return ~d;
    endcase
  endfunction

  // 17-bit sum so a large step cannot wrap below LEN_MAX
  assign len_sum = {1'b0, cur_len} + {1'b0, LEN_STEP};

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    go          = 1'b0;
    pkt_ok      = 1'b0;
    abort       = 1'b0;
    camp_done   = 1'b0;
    tx_start_en = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (gen_en && armed) begin
          go        = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_start_en = 1'b1;
        state_nxt   = SEND;
      end
      SEND: begin
        // tx_done wins over a watchdog expiry in the same cycle
        if (tx_done) begin
          pkt_ok    = 1'b1;
          state_nxt = GAP;
        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          if (PKT_NUM != 16'd0 && pkt_cnt == PKT_NUM) begin
            camp_done = 1'b1;
            state_nxt = IDLE;
          end else if (!gen_en) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = START;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode        <= 2'd0;
      cur_len     <= LEN_MIN;
      wdog        <= '0;
      gap_cnt     <= '0;
      armed       <= 1'b1;
      tx_byte_num <= '0;
      tx_data     <= '0;
      pkt_cnt     <= '0;
      gen_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      gen_done <= camp_done;
      // a finished counted campaign disarms until gen_en is seen low
      if (!gen_en)        armed <= 1'b1;
      else if (camp_done) armed <= 1'b0;

      wdog    <= (state == SEND) ? wdog + WD_W'(1) : '0;
      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;

      if (go) begin
        mode    <= pattern_mode;
        pkt_cnt <= '0;
        cur_len <= LEN_MIN;
      end

      if (state_nxt == START) begin
        // from IDLE the fresh campaign values are not registered yet
        tx_byte_num <= go ? LEN_MIN : cur_len;
        tx_data     <= seed_of(go ? pattern_mode : mode);
      end else if (pkt_ok) begin
        tx_data <= seed_of(mode);
        pkt_cnt <= pkt_cnt + 16'd1;
        cur_len <= (len_sum > {1'b0, LEN_MAX}) ? LEN_MIN : len_sum[15:0];
      end else if (state == SEND && tx_req) begin
        tx_data <= next_of(mode, tx_data);
      end

      if (abort) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_pkt_gen.sv
// Testbench for eth_pkt_gen. Two instances share all inputs: u_run runs
// an open-ended campaign (PKT_NUM=0), u_cnt a counted one (PKT_NUM=2).
// Both use a 50-cycle watchdog. The reference model predicts payload words
// in closed form from the number of requests served.
module tb_eth_pkt_gen;
  localparam int DW    = 32;
  localparam int LMIN  = 20;
  localparam int LMAX  = 28;
  localparam int LSTEP = 8;
  localparam int GAP   = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          gen_en = 1'b0;
  logic [1:0]    pattern_mode = 2'd0;
  logic          tx_req = 1'b0;
  logic          tx_done = 1'b0;

  logic          r_start, r_busy, r_gdone, r_terr;
  logic [15:0]   r_len, r_cnt;
  logic [DW-1:0] r_data;
  logic          c_start, c_busy, c_gdone, c_terr;
  logic [15:0]   c_len, c_cnt;
  logic [DW-1:0] c_data;

  always #5 clk = ~clk;

  eth_pkt_gen #(.DATA_W(DW), .PKT_NUM(16'd0), .TIMEOUT(50)) u_run (
    .gmii_tx_clk(clk), .rst_n(rst_n), .gen_en(gen_en), .pattern_mode(pattern_mode),
    .tx_start_en(r_start), .tx_byte_num(r_len), .tx_data(r_data),
    .tx_req(tx_req), .tx_done(tx_done), .busy(r_busy), .pkt_cnt(r_cnt),
    .gen_done(r_gdone), .timeout_err(r_terr));

  eth_pkt_gen #(.DATA_W(DW), .PKT_NUM(16'd2), .TIMEOUT(50)) u_cnt (
    .gmii_tx_clk(clk), .rst_n(rst_n), .gen_en(gen_en), .pattern_mode(pattern_mode),
    .tx_start_en(c_start), .tx_byte_num(c_len), .tx_data(c_data),
    .tx_req(tx_req), .tx_done(tx_done), .busy(c_busy), .pkt_cnt(c_cnt),
    .gen_done(c_gdone), .timeout_err(c_terr));

  int checks = 0;
  int errors = 0;
  int c_starts = 0;
  int c_dones = 0;
  int r_gdones = 0;
  int exp_len, exp_cnt;
  logic [1:0] exp_mode;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // all sampling and input driving happens on the falling edge
  task automatic tick();
    @(negedge clk);
    if (c_start) c_starts++;
    if (c_gdone) c_dones++;
    if (r_gdone) r_gdones++;
  endtask

  function automatic logic [DW-1:0] exp_word(input logic [1:0] m, input int n);
    case (m)
      2'd0:    return DW'(n);
      2'd1:    return {4{8'hA5}};
      2'd2:    return 32'h1 << (n % DW);
      default: return n[0] ? '1 : '0;
    endcase
  endfunction

  task automatic wait_start(input string tag, input int lim, input int exp_n);
    int n = 0;
    while (!r_start && n < lim) begin tick(); n++; end
    chk({tag, "_wait"}, 64'(n), 64'(exp_n));
  endtask

  task automatic wait_idle(input string tag, input int exp_n);
    int n = 0;
    while (r_busy && n < 300) begin tick(); n++; end
    chk({tag, "_idle"}, 64'(n), 64'(exp_n));
  endtask

  // called on the start-pulse sample; serves nreq words then tx_done
  task automatic run_pkt(input int nreq, input bit both);
    chk("start_len", r_len, exp_len);
    chk("start_seed", r_data, exp_word(exp_mode, 0));
    chk("start_cnt", r_cnt, exp_cnt);
    tick();
    chk("start_1cyc", r_start, 0);
    for (int i = 1; i <= nreq; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      pattern_mode = 2'($urandom);
      tx_req = 1'b1; tick(); tx_req = 1'b0;
      chk("data", r_data, exp_word(exp_mode, i));
    end
    tx_done = 1'b1; tx_req = both; tick(); tx_done = 1'b0; tx_req = 1'b0;
    chk("done_seed", r_data, exp_word(exp_mode, 0));
    exp_cnt++;
    chk("done_cnt", r_cnt, exp_cnt);
    chk("done_len_hold", r_len, exp_len);
    exp_len = (exp_len + LSTEP > LMAX) ? LMIN : exp_len + LSTEP;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [1:0] modes [4];
    modes[0] = 2'd2; modes[1] = 2'd1; modes[2] = 2'd3; modes[3] = 2'($urandom);

    // reset state
    repeat (3) tick();
    chk("rst_start", r_start, 0); chk("rst_len", r_len, 0); chk("rst_data", r_data, 0);
    chk("rst_busy", r_busy, 0); chk("rst_cnt", r_cnt, 0); chk("rst_terr", r_terr, 0);
    rst_n = 1'b1; tick();

    // counted and open campaign, mode 0
    pattern_mode = 2'd0; exp_mode = 2'd0; exp_len = LMIN; exp_cnt = 0;
    gen_en = 1'b1;
    wait_start("p1", 5, 1);
    chk("c_start_same", c_start, 1);
    run_pkt(5, 1'b0);
    wait_start("gap1", 300, GAP);
    run_pkt($urandom_range(1, 8), 1'b1);   // tx_req coincides with tx_done
    chk("c_cnt2", c_cnt, 2);
    wait_start("gap2", 300, GAP);
    chk("c_gdone", c_gdone, 1);
    chk("c_busy_off", c_busy, 0);
    chk("c_cnt_hold", c_cnt, 2);
    gen_en = 1'b0;                          // drop mid third packet
    run_pkt($urandom_range(1, 8), 1'b0);
    wait_idle("p3", GAP);
    chk("r_cnt_hold", r_cnt, 3);
    chk("r_len_hold", r_len, LMIN);
    chk("c_starts", 64'(c_starts), 2);
    chk("c_dones", 64'(c_dones), 1);
    chk("r_gdones", 64'(r_gdones), 0);

    // payload patterns, one packet per campaign
    for (int k = 0; k < 4; k++) begin
      tick();
      pattern_mode = modes[k]; exp_mode = modes[k]; exp_len = LMIN; exp_cnt = 0;
      gen_en = 1'b1;
      wait_start("pat", 5, 1);
      gen_en = 1'b0;
      run_pkt($urandom_range(4, 8), 1'b0);
      wait_idle("pat", GAP);
    end

    // watchdog abort and retry of the same length
    tick();
    pattern_mode = 2'd0; exp_mode = 2'd0; exp_len = LMIN; exp_cnt = 0;
    gen_en = 1'b1;
    wait_start("to", 5, 1);
    chk("to_len", r_len, LMIN);
    chk("to_terr0", r_terr, 0);
    for (int k = 0; k < 50; k++) begin tx_req = 1'($urandom); tick(); end
    chk("to_terr_early", r_terr, 0);
    tx_req = 1'b0; tick();
    chk("to_terr", r_terr, 1);
    chk("to_cnt", r_cnt, 0);
    chk("to_busy", r_busy, 1);
    wait_start("to_gap", 300, GAP);
    gen_en = 1'b0;
    run_pkt($urandom_range(1, 8), 1'b0);
    wait_idle("to_retry", GAP);
    chk("terr_sticky", r_terr, 1);

    // asynchronous reset during SEND
    tick();
    pattern_mode = 2'd3; exp_mode = 2'd3; exp_len = LMIN; exp_cnt = 0;
    gen_en = 1'b1;
    wait_start("rs", 5, 1);
    tick();
    tx_req = 1'b1; tick(); tx_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_start", r_start, 0); chk("ar_len", r_len, 0); chk("ar_data", r_data, 0);
    chk("ar_busy", r_busy, 0); chk("ar_cnt", r_cnt, 0); chk("ar_terr", r_terr, 0);
    chk("ar_gdone", r_gdone, 0);
    tick();
    chk("ar_busy2", r_busy, 0);
    rst_n = 1'b1;
    wait_start("rs_after", 5, 1);
    gen_en = 1'b0;
    run_pkt($urandom_range(1, 8), 1'b0);
    wait_idle("rs_after", GAP);
    chk("rs_terr", r_terr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_pkt_gen.md
Name: eth_pkt_gen

Overview:
Synthesisable Ethernet test-traffic generator. It drives the user-side TX handshake of the ICMP/UDP packet engines (tx_start_en, tx_byte_num, tx_data against tx_req, tx_done). It emits a campaign of packets with stepped lengths, selectable payload patterns and a programmable inter-packet gap. A watchdog aborts a packet when the engine never returns tx_done. It sits between the board control logic and the protocol TX module, in the gmii_tx_clk domain.

Parameters:
DATA_W, 32, width of tx_data; must be a multiple of 8.
LEN_MIN, 16'd20, first and wrap-back payload length in bytes.
LEN_MAX, 16'd28, largest payload length in bytes.
LEN_STEP, 16'd8, length increment after each completed packet.
GAP_CYCLES, 100, idle cycles between tx_done and the next start.
PKT_NUM, 16'd0, packets per campaign; 0 means run until gen_en is deasserted.
TIMEOUT, 4096, maximum cycles in SEND before the packet is aborted.

Ports:
gmii_tx_clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
gen_en  in  1  level; a campaign starts while high.
pattern_mode  in  2  payload pattern; sampled when leaving IDLE.
tx_start_en  out  1  one-cycle start pulse to the TX engine.
tx_byte_num  out  16  payload byte count; stable from the start pulse until tx_done.
tx_data  out  DATA_W  payload word.
tx_req  in  1  TX engine requests the next word.
tx_done  in  1  TX engine reports the packet is complete (one-cycle pulse).
busy  out  1  high in every state except IDLE.
pkt_cnt  out  16  packets completed in the current campaign.
gen_done  out  1  one-cycle pulse when PKT_NUM packets have completed.
timeout_err  out  1  sticky; set by any watchdog abort.

Behaviour:
- Reset: all outputs are 0; state is IDLE; cur_len=LEN_MIN; gap and watchdog counters are 0.
- FSM states: IDLE, START, SEND, GAP.
- IDLE: when gen_en=1, latch pattern_mode, clear pkt_cnt, set cur_len=LEN_MIN, and go to START.
- START (1 cycle): tx_start_en=1, tx_byte_num=cur_len, tx_data=seed, watchdog=0; go to SEND. tx_start_en is never high for two consecutive cycles.
- Seeds per pattern_mode:
  - 0 (increment): seed 0.
  - 1 (constant): seed is 8'hA5 replicated DATA_W/8 times.
  - 2 (walking one): seed 1.
  - 3 (toggle): seed 0.
- SEND, data updates: each cycle with tx_req=1 updates tx_data on the next edge.
  - Mode 0: +1, wrapping modulo 2^DATA_W.
  - Mode 1: unchanged.
  - Mode 2: rotate left by 1.
  - Mode 3: bitwise invert.
- SEND, tx_done=1:
  - tx_data returns to its seed. tx_done has priority over a simultaneous tx_req.
  - pkt_cnt increments, wrapping 65535 to 0 when PKT_NUM=0.
  - cur_len becomes cur_len+LEN_STEP, or LEN_MIN if the sum exceeds LEN_MAX (computed in 17 bits).
  - Go to GAP.
- SEND, watchdog: the counter increments every cycle in SEND. If it reaches TIMEOUT-1 without tx_done:
  - set timeout_err;
  - leave pkt_cnt and cur_len unchanged;
  - go to GAP, so the same length is retried.
- GAP: count GAP_CYCLES cycles, then:
  - if PKT_NUM!=0 and pkt_cnt==PKT_NUM: pulse gen_done for 1 cycle and go to IDLE;
  - else if gen_en=0: go to IDLE;
  - else: go to START.
- A completed PKT_NUM campaign does not restart while gen_en stays high. The next campaign requires gen_en to fall and rise again (track with a registered armed flag).
- gen_en falling during START or SEND: the current packet completes or times out normally, and the block returns to IDLE at the end of GAP.
- pattern_mode changes during a campaign are ignored.
- tx_req in IDLE, START or GAP is ignored. tx_done outside SEND is ignored.
- tx_byte_num holds its last value in IDLE.
- pkt_cnt holds its value in IDLE until the next campaign starts.
- timeout_err clears only on reset.
- Asserting rst_n low mid-packet returns everything to reset values immediately, with no completion pulse.

Test Plan:
1. Defaults, PKT_NUM=2, mode 0. Raise gen_en; the engine gives 5 tx_req then tx_done.
   - Required: tx_start_en pulse with tx_byte_num=20, tx_data 0→1…→5.
   - Then exactly 100 idle cycles, a second pulse with tx_byte_num=28, tx_done, and a gen_done pulse with pkt_cnt=2.
   - No third start while gen_en stays 1.
2. PKT_NUM=0, 3 packets.
   - Required: lengths 20, 28, 20 (wrap because 36>28).
   - Drop gen_en mid-third packet: that packet finishes, then the block returns to IDLE and busy=0.
3. Mode 2, DATA_W=32, 4 tx_req.
   - Required: tx_data 1, 2, 4, 8, 16.
   - Mode 1: A5A5A5A5 constant.
   - Mode 3: 0, FFFFFFFF, 0.
4. Same-cycle tx_req and tx_done.
   - Required: tx_data returns to the seed and pkt_cnt increments by exactly 1.
5. TIMEOUT=50, engine never asserts tx_done.
   - Required: timeout_err=1 at cycle 49 of SEND, pkt_cnt unchanged.
   - After 100 gap cycles the retry uses tx_byte_num=20.
6. Assert rst_n low during SEND.
   - Required: all outputs 0 asynchronously, state IDLE.
   - After release with gen_en=1, a clean start with tx_byte_num=20.
